// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-requester arbiter that time-shares one combinational ALU,
//             holding a single operation through IDLE -> EXEC -> RESP.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
   parameter bit SCRUB = 1'b1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [31:0] i_req0_rs,
   input  logic [31:0] i_req0_rt,
   input  logic [31:0] i_req0_imm,
   input  logic        i_req0_useimm,
   input  logic [7:0]  i_req0_sel,
   input  logic        i_req0_label,

   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [31:0] i_req1_rs,
   input  logic [31:0] i_req1_rt,
   input  logic [31:0] i_req1_imm,
   input  logic        i_req1_useimm,
   input  logic [7:0]  i_req1_sel,
   input  logic        i_req1_label,

   output logic [31:0] o_alu_rs,
   output logic [31:0] o_alu_rt,
   output logic [31:0] o_alu_imm,
   output logic        o_alu_useimm,
   output logic [7:0]  o_alu_sel,
   output logic        o_alu_label,
   input  logic [31:0] i_alu_out,

   output logic        o_rsp0_valid,
   input  logic        i_rsp0_ready,
   output logic        o_rsp1_valid,
   input  logic        i_rsp1_ready,
   output logic [31:0] o_rsp_data,
   output logic        o_rsp_label,

   output logic        o_busy,
   output logic [15:0] o_op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic        r_owner;
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [31:0] r_imm;
   logic        r_useimm;
   logic [7:0]  r_sel;
   logic        r_label;
   logic [31:0] r_rsp_data;
   logic        r_rsp_label;
   logic        r_rsp0_valid;
   logic        r_rsp1_valid;
   logic [15:0] r_op_count;

   logic        w_idle;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_accept;
   logic        w_owner_ready;

   // Requester 1 wins a tie only when requester 0 was served last.
   assign w_gnt1        = i_req1_valid & (~i_req0_valid | ~r_last_grant);
   assign w_gnt0        = i_req0_valid & ~w_gnt1;
   assign w_idle        = (r_state == S_IDLE) & ~reset;
   assign w_accept      = w_idle & (w_gnt0 | w_gnt1);
   assign w_owner_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;

   assign o_req0_ready  = w_idle & w_gnt0;
   assign o_req1_ready  = w_idle & w_gnt1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_rs         <= 32'd0;
         r_rt         <= 32'd0;
         r_imm        <= 32'd0;
         r_useimm     <= 1'b0;
         r_sel        <= 8'd0;
         r_label      <= 1'b0;
         r_rsp_data   <= 32'd0;
         r_rsp_label  <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_op_count   <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_owner      <= w_gnt1;
                  r_last_grant <= w_gnt1;
                  r_rs         <= w_gnt1 ? i_req1_rs      : i_req0_rs;
                  r_rt         <= w_gnt1 ? i_req1_rt      : i_req0_rt;
                  r_imm        <= w_gnt1 ? i_req1_imm     : i_req0_imm;
                  r_useimm     <= w_gnt1 ? i_req1_useimm  : i_req0_useimm;
                  r_sel        <= w_gnt1 ? i_req1_sel     : i_req0_sel;
                  r_label      <= w_gnt1 ? i_req1_label   : i_req0_label;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_data   <= i_alu_out;
               r_rsp_label  <= r_label;
               r_rsp0_valid <= ~r_owner;
               r_rsp1_valid <= r_owner;
               // Operand registers feed the ALU directly, so clearing them
               // here keeps the ALU inputs quiet outside EXEC.
               if (SCRUB) begin
                  r_rs     <= 32'd0;
                  r_rt     <= 32'd0;
                  r_imm    <= 32'd0;
                  r_useimm <= 1'b0;
                  r_sel    <= 8'd0;
                  r_label  <= 1'b0;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (w_owner_ready) begin
                  r_rsp_data   <= 32'd0;
                  r_rsp_label  <= 1'b0;
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_op_count   <= r_op_count + 16'd1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_alu_rs     = r_rs;
   assign o_alu_rt     = r_rt;
   assign o_alu_imm    = r_imm;
   assign o_alu_useimm = r_useimm;
   assign o_alu_sel    = r_sel;
   assign o_alu_label  = r_label;

   assign o_rsp0_valid = r_rsp0_valid;
   assign o_rsp1_valid = r_rsp1_valid;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_label  = r_rsp_label;

   assign o_busy       = (r_state != S_IDLE);
   assign o_op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter with a small ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

   localparam logic [7:0] c_SEL_ADD = 8'h01;
   localparam logic [7:0] c_SEL_XOR = 8'h06;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_rs, req0_rt, req0_imm, req1_rs, req1_rt, req1_imm;
   logic        req0_useimm, req0_label, req1_useimm, req1_label;
   logic [7:0]  req0_sel, req1_sel;
   logic [31:0] alu_rs, alu_rt, alu_imm, alu_out;
   logic        alu_useimm, alu_label;
   logic [7:0]  alu_sel;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_data;
   logic        rsp_label, busy;
   logic [15:0] op_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Reference ALU driven by the arbiter's operand outputs.
   logic [31:0] alu_b;
   always_comb begin
      alu_b   = alu_useimm ? alu_imm : alu_rt;
      alu_out = 32'd0;
      case (alu_sel)
         c_SEL_ADD: alu_out = alu_rs + alu_b;
         c_SEL_XOR: alu_out = alu_rs ^ alu_b;
         default:   alu_out = 32'd0;
      endcase
   end

   alu_arbiter #(.SCRUB(1'b1)) dut (
      .clk(clk), .reset(reset),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
      .i_req0_rs(req0_rs), .i_req0_rt(req0_rt), .i_req0_imm(req0_imm),
      .i_req0_useimm(req0_useimm), .i_req0_sel(req0_sel), .i_req0_label(req0_label),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
      .i_req1_rs(req1_rs), .i_req1_rt(req1_rt), .i_req1_imm(req1_imm),
      .i_req1_useimm(req1_useimm), .i_req1_sel(req1_sel), .i_req1_label(req1_label),
      .o_alu_rs(alu_rs), .o_alu_rt(alu_rt), .o_alu_imm(alu_imm),
      .o_alu_useimm(alu_useimm), .o_alu_sel(alu_sel), .o_alu_label(alu_label),
      .i_alu_out(alu_out),
      .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
      .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
      .o_rsp_data(rsp_data), .o_rsp_label(rsp_label),
      .o_busy(busy), .o_op_count(op_count)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single req0 operation from IDLE through completion.
   task automatic run_op0(input logic [31:0] rs, input logic [31:0] rt);
      req0_rs = rs; req0_rt = rt; req0_sel = c_SEL_ADD; req0_useimm = 1'b0;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_rs = 0; req0_rt = 0; req0_imm = 0; req0_useimm = 0; req0_sel = 0; req0_label = 0;
      req1_valid = 0; req1_rs = 0; req1_rt = 0; req1_imm = 0; req1_useimm = 0; req1_sel = 0; req1_label = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_opcount", {16'd0, op_count}, 32'd0);
      check_value("rst_rspdata", rsp_data, 32'd0);
      reset = 1'b0;

      // Single add: accept in A, ALU in A+1, response in A+2
      req0_rs = 32'd5; req0_rt = 32'd7; req0_sel = c_SEL_ADD; req0_valid = 1'b1;
      #1;
      check_value("op1_req0_ready", {31'd0, req0_ready}, 32'd1);
      tick();
      check_value("op1_exec_sel", {24'd0, alu_sel}, {24'd0, c_SEL_ADD});
      check_value("op1_exec_rs", alu_rs, 32'd5);
      check_value("op1_exec_rt", alu_rt, 32'd7);
      check_value("op1_exec_ready0", {31'd0, req0_ready}, 32'd0);
      check_value("op1_exec_busy", {31'd0, busy}, 32'd1);
      req0_valid = 1'b0;
      tick();
      check_value("op1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check_value("op1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check_value("op1_rsp_data", rsp_data, 32'd12);
      check_value("op1_resp_alu_rs", alu_rs, 32'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      check_value("op1_opcount", {16'd0, op_count}, 32'd1);
      check_value("op1_idle_rsp_data", rsp_data, 32'd0);
      check_value("op1_idle_busy", {31'd0, busy}, 32'd0);

      // High-label xor on requester 1
      req1_rs = 32'hFFFF0000; req1_rt = 32'h0000FFFF; req1_sel = c_SEL_XOR; req1_label = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_value("lbl_idle_alu_label", {31'd0, alu_label}, 32'd0);
      check_value("lbl_req1_ready", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      check_value("lbl_exec_alu_label", {31'd0, alu_label}, 32'd1);
      check_value("lbl_exec_sel", {24'd0, alu_sel}, {24'd0, c_SEL_XOR});
      tick();
      check_value("lbl_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check_value("lbl_rsp_label", {31'd0, rsp_label}, 32'd1);
      check_value("lbl_rsp_data", rsp_data, 32'hFFFFFFFF);
      check_value("lbl_resp_alu_label", {31'd0, alu_label}, 32'd0);
      check_value("lbl_resp_alu_rt", alu_rt, 32'd0);
      check_value("lbl_resp_alu_sel", {24'd0, alu_sel}, 32'd0);
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      check_value("lbl_opcount", {16'd0, op_count}, 32'd2);
      check_value("lbl_idle_rsp_label", {31'd0, rsp_label}, 32'd0);
      req1_label = 1'b0;

      // Immediate operand path
      req0_rs = 32'd10; req0_rt = 32'd999; req0_imm = 32'd32; req0_useimm = 1'b1;
      req0_sel = c_SEL_ADD; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      check_value("imm_exec_useimm", {31'd0, alu_useimm}, 32'd1);
      check_value("imm_exec_imm", alu_imm, 32'd32);
      tick();
      check_value("imm_rsp_data", rsp_data, 32'd42);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      req0_useimm = 1'b0;

      // Backpressure on requester 1 with requester 0 waiting
      req1_rs = 32'd100; req1_rt = 32'd23; req1_sel = c_SEL_ADD; req1_label = 1'b1;
      req1_valid = 1'b1;
      tick();
      req1_valid = 1'b0;
      tick();
      req0_rs = 32'd1; req0_rt = 32'd1; req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rsp0_ready = i[0];
         #1;
         check_value("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
         check_value("bp_rsp_data", rsp_data, 32'd123);
         check_value("bp_rsp_label", {31'd0, rsp_label}, 32'd1);
         check_value("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
         tick();
      end
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      check_value("bp_done_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check_value("bp_opcount", {16'd0, op_count}, 32'd4);
      check_value("bp_req0_eligible", {31'd0, req0_ready}, 32'd1);
      req0_valid = 1'b0;
      req1_label = 1'b0;

      // Asynchronous reset while a response is pending
      req0_rs = 32'd1; req0_rt = 32'd2; req0_sel = c_SEL_ADD;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      check_value("ar_pre_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check_value("ar_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check_value("ar_busy", {31'd0, busy}, 32'd0);
      check_value("ar_opcount", {16'd0, op_count}, 32'd0);
      check_value("ar_rsp_data", rsp_data, 32'd0);

      // Contention straight out of reset: strict alternation 0,1,0,1
      req0_rs = 32'd1; req0_rt = 32'd3; req0_sel = c_SEL_ADD;
      req1_rs = 32'd2; req1_rt = 32'd3; req1_sel = c_SEL_ADD;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1 reset = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check_value("ct_idle_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check_value("ct_idle_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check_value("ct_exec_ready0", {31'd0, req0_ready}, 32'd0);
         check_value("ct_exec_ready1", {31'd0, req1_ready}, 32'd0);
         tick();
         check_value("ct_rsp0_valid", {31'd0, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check_value("ct_rsp1_valid", {31'd0, rsp1_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check_value("ct_rsp_data", rsp_data, (k % 2 == 0) ? 32'd4 : 32'd5);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      check_value("ct_opcount", {16'd0, op_count}, 32'd4);

      // Counter wrap from a preloaded value near the top
      force dut.r_op_count = 16'hFFFE;
      #1;
      release dut.r_op_count;
      tick();
      run_op0(32'd3, 32'd4);
      check_value("wrap_ffff", {16'd0, op_count}, 32'h0000FFFF);
      run_op0(32'd3, 32'd4);
      check_value("wrap_zero", {16'd0, op_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SCRUB, default 1: when 1, ALU operand outputs are forced to zero whenever no operation is executing.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_rs, reqN_rt, reqN_imm  input  32 each  requester N operands.
REQ-007 reqN_useimm  input  1  requester N immediate-select.
REQ-008 reqN_sel  input  8  requester N operation select (mips.h select_alu_* encodings).
REQ-009 reqN_label  input  1  requester N security label (0 low, 1 high).
REQ-010 alu_rs, alu_rt, alu_imm  output  32 each  operands to shared ALU.
REQ-011 alu_useimm  output  1; alu_sel  output  8; alu_label  output  1  ALU controls and label.
REQ-012 alu_out  input  32  combinational ALU result.
REQ-013 rspN_valid  output  1  result ready for requester N.
REQ-014 rspN_ready  input  1  requester N consumes result.
REQ-015 rsp_data  output  32; rsp_label  output  1  shared result and its label.
REQ-016 busy  output  1  state is not IDLE.
REQ-017 op_count  output  16  completed-operation counter.

Function
REQ-018 States: IDLE, EXEC, RESP; the module SHALL hold exactly one operation at a time.
REQ-019 In IDLE, grant SHALL go to the sole valid requester; if both valid, to the requester not granted last (last_grant register).
REQ-020 reqN_ready SHALL be 1 only in IDLE for the granted requester; it SHALL be 0 in EXEC and RESP.
REQ-021 Acceptance (valid&ready) SHALL register the granted operands, sel, useimm, label and owner id, and move IDLE->EXEC; last_grant SHALL update to the owner.
REQ-022 In EXEC, alu_* outputs SHALL equal the registered operation; alu_out SHALL be captured into rsp_data/rsp_label at the end of the cycle; EXEC->RESP unconditionally.
REQ-023 In RESP, rsp<owner>_valid SHALL be 1, the other rspN_valid 0; rsp_data/rsp_label SHALL stay stable until rsp<owner>_ready=1.
REQ-024 RESP with rsp<owner>_ready=1 SHALL go to IDLE next cycle and increment op_count by 1, wrapping 0xFFFF->0x0000.
REQ-025 rspN_ready of the non-owner SHALL be ignored.
REQ-026 Latency: accept in cycle A -> rsp_valid in cycle A+2; maximum throughput one operation per 3 cycles.
REQ-027 With SCRUB=1, alu_rs/rt/imm/sel/useimm/label SHALL be 0 outside EXEC and the operand registers SHALL clear on leaving EXEC; with SCRUB=0 they SHALL hold the last operation.
REQ-028 rsp_data SHALL be 0 whenever no rspN_valid is asserted.
REQ-029 Requests SHALL not be dropped: a valid not granted SHALL remain eligible and win the next IDLE if the other requester was last granted.

Reset
REQ-030 Asserting reset at any time, including mid-EXEC or mid-RESP, SHALL immediately force IDLE, discard the pending operation, and zero all outputs, op_count, operand registers and rsp_data.
REQ-031 Reset SHALL set last_grant=1 so requester 0 wins the first simultaneous request.
REQ-032 After reset deassertion the first acceptance SHALL be possible in the first clock cycle.

Verification
REQ-033 Single op: req0 add rs=5 rt=7 useimm=0 in cycle A -> alu_sel=select_alu_add, alu_rs=5 in A+1; rsp0_valid=1, rsp_data=12 in A+2; op_count=1 after rsp0_ready.
REQ-034 Contention: both valid from reset, each holding after acceptance -> order req0, req1, req0, req1; each reqN_ready pulse lasts one cycle.
REQ-035 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid, rsp_data, rsp_label stable; req0_ready=0 throughout; rsp0_ready pulses ignored.
REQ-036 Label/scrub: req1 label=1 xor 0xFFFF0000^0x0000FFFF -> alu_label=1 only in EXEC, rsp_label=1, rsp_data=0xFFFFFFFF; alu_* all 0 in IDLE and RESP (SCRUB=1).
REQ-037 Reset mid-RESP: reset asserted asynchronously while rsp0_valid=1 -> rsp0_valid, busy, op_count drop to 0 without a clock edge; next contention grants req0.
REQ-038 Wrap: preload via 65536 completed ops -> op_count 0xFFFF->0x0000.
